// File: rtl/conv_15_acc_pkg.sv
// Shared types and width helpers for the conv_15 accumulate/requantise block.
package conv_15_acc_pkg;

  localparam int N_TAPS_DEF = 9;
  localparam int PROD_W_DEF = 24;
  localparam int ACC_W_DEF  = 32;
  localparam int SHIFT_DEF  = 8;
  localparam int OUT_W_DEF  = 16;

  // Rounded sum is carried one bit wider than the accumulator so it never wraps.
  localparam int RND_W   = ACC_W_DEF + 1;
  localparam int OUT_MAX = 2 ** (OUT_W_DEF - 1) - 1;
  localparam int OUT_MIN = -(2 ** (OUT_W_DEF - 1));

  typedef enum logic [1:0] {
    ACC = 2'd0,
    RQ  = 2'd1,
    OUT = 2'd2
  } state_t;

  function automatic int cnt_width(input int n_taps);
    return $clog2(n_taps) + 1;
  endfunction

  function automatic int rnd_width(input int acc_w);
    return acc_w + 1;
  endfunction

endpackage

// File: rtl/conv_15_requant_sat.sv
// Combinational requantiser: round-half-up, arithmetic shift, optional ReLU, saturate.
module conv_15_requant_sat #(
  parameter int ACC_W = 32,
  parameter int SHIFT = 8,
  parameter int OUT_W = 16
) (
  input  logic signed [ACC_W-1:0] acc_in,
  input  logic                    relu_en,
  output logic signed [OUT_W-1:0] q_out
);

  localparam int                RSH     = (SHIFT == 0) ? 0 : SHIFT - 1;
  localparam logic [ACC_W:0]    RND_U   = (ACC_W + 1)'(1) << RSH;
  localparam logic signed [ACC_W:0] RND = (SHIFT == 0) ? '0 : $signed(RND_U);
  localparam logic signed [ACC_W:0] SAT_MAX =
    {{(ACC_W - OUT_W + 2){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [ACC_W:0] SAT_MIN =
    {{(ACC_W - OUT_W + 2){1'b1}}, {(OUT_W - 1){1'b0}}};

  function automatic logic signed [ACC_W:0] f_round_shift(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W:0] r;
    r = $signed({a[ACC_W-1], a}) + RND;
    return r >>> SHIFT;
  endfunction

  function automatic logic signed [OUT_W-1:0] f_sat(input logic signed [ACC_W:0] s,
                                                    input logic relu);
    if (relu && (s < 0))    return '0;
    else if (s > SAT_MAX)   return SAT_MAX[OUT_W-1:0];
    else if (s < SAT_MIN)   return SAT_MIN[OUT_W-1:0];
    else                    return s[OUT_W-1:0];
  endfunction

  logic signed [ACC_W:0] w_shifted;

  assign w_shifted = f_round_shift(acc_in);
  assign q_out     = f_sat(w_shifted, relu_en);

endmodule

// File: rtl/conv_15_acc_requant.sv
// Accumulates N_TAPS products per pixel on top of a bias, then requantises to OUT_W bits.
module conv_15_acc_requant
  import conv_15_acc_pkg::*;
#(
  parameter int N_TAPS = N_TAPS_DEF,
  parameter int PROD_W = PROD_W_DEF,
  parameter int ACC_W  = ACC_W_DEF,
  parameter int SHIFT  = SHIFT_DEF,
  parameter int OUT_W  = OUT_W_DEF
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst,
  input  logic signed [PROD_W-1:0] prod_din,
  input  logic                    prod_valid,
  output logic                    prod_ready,
  input  logic signed [ACC_W-1:0] bias,
  input  logic                    relu_en,
  output logic signed [OUT_W-1:0] out_dout,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    busy
);

  localparam int               CNT_W = cnt_width(N_TAPS);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(N_TAPS - 1);

  state_t                  r_state;
  state_t                  w_next;
  logic [CNT_W-1:0]        r_cnt;
  logic signed [ACC_W-1:0] r_acc;
  logic                    r_relu;
  logic signed [OUT_W-1:0] r_dout;
  logic                    r_valid;

  logic                    w_prod_hs;
  logic                    w_out_hs;
  logic                    w_last;
  logic signed [ACC_W-1:0] w_prod_ext;
  logic signed [OUT_W-1:0] w_q;

  assign w_prod_hs  = prod_valid & prod_ready;
  assign w_out_hs   = r_valid & out_ready;
  assign w_last     = (r_cnt == LAST);
  assign w_prod_ext = {{(ACC_W - PROD_W){prod_din[PROD_W-1]}}, prod_din};

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) r_state <= ACC;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ACC:     if (w_prod_hs && w_last) w_next = RQ;
      RQ:      w_next = OUT;
      OUT:     if (w_out_hs) w_next = ACC;
      default: w_next = ACC;
    endcase
  end

  always_comb begin
    prod_ready = (r_state == ACC);
    busy       = (r_cnt != '0) | (r_state != ACC);
  end

  // Accumulate stage: bias and ReLU mode are captured only with the first tap.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_cnt  <= '0;
      r_acc  <= '0;
      r_relu <= 1'b0;
    end else if (w_prod_hs) begin
      if (r_cnt == '0) begin
        r_acc  <= bias + w_prod_ext;
        r_relu <= relu_en;
      end else begin
        r_acc  <= r_acc + w_prod_ext;
      end
      r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
    end
  end

  conv_15_requant_sat #(
    .ACC_W (ACC_W),
    .SHIFT (SHIFT),
    .OUT_W (OUT_W)
  ) u_rq (
    .acc_in  (r_acc),
    .relu_en (r_relu),
    .q_out   (w_q)
  );

  // Output stage: result is held until the writeback side takes it.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_dout  <= '0;
      r_valid <= 1'b0;
    end else if (r_state == RQ) begin
      r_dout  <= w_q;
      r_valid <= 1'b1;
    end else if (w_out_hs) begin
      r_valid <= 1'b0;
    end
  end

  assign out_dout  = r_dout;
  assign out_valid = r_valid;

endmodule
